// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//   Bridges a 32-bit single-word request port into accesses on an external
//   asynchronous 16-bit SRAM. Each word is split into two halfword accesses,
//   low half first. Each half is an ADDR / STB / REC sequence, and the strobe
//   is held for WAIT_STATES cycles.
//
// Handshake: the master raises sval with saddr/sdtw/srw and holds it until it
//   sees srdy. The request is captured on the first rising edge where the FSM
//   is IDLE and sval=1. srdy is a one-cycle pulse in DONE. Inputs are ignored
//   from the capture edge until the FSM is back in IDLE.
//
// Ports:
//   clk, reset (async, active-low)
//   sval/srdy/saddr/sdtw/sdtr/srw  - request side (byte address, 32-bit data)
//   sram_addr                      - external halfword address
//   sram_dq_o/sram_dq_i/sram_dq_oe - data pad out / in / output enable
//   sram_ce_n/sram_oe_n/sram_we_n  - active-low SRAM strobes
//   dbg_state                      - current FSM state encoding (debug only)
//
// Parameters:
//   WAIT_STATES - strobe width in cycles; legal range 1..15
//   ADDR_WIDTH  - width of sram_addr
// -----------------------------------------------------------------------------
module sram_ctrl #(
   parameter int WAIT_STATES = 1,
   parameter int ADDR_WIDTH  = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sval,
   output logic                  srdy,
   input  logic [31:0]           saddr,
   input  logic [31:0]           sdtw,
   output logic [31:0]           sdtr,
   input  logic                  srw,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [15:0]           sram_dq_o,
   input  logic [15:0]           sram_dq_i,
   output logic                  sram_dq_oe,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic [2:0]            dbg_state
);

   // The encoding is visible on dbg_state, so keep these values stable.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LO_ADDR = 3'd1,
      LO_STB  = 3'd2,
      LO_REC  = 3'd3,
      HI_ADDR = 3'd4,
      HI_STB  = 3'd5,
      HI_REC  = 3'd6,
      DONE    = 3'd7
   } state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-2:0] a_q;    // word address, saddr[ADDR_WIDTH:2]
   logic [31:0]           d_q;
   logic                  w_q;
   logic [15:0]           lo_q;
   logic [15:0]           hi_q;

   assign dbg_state = state;

   // saddr[1:0] and the bits above ADDR_WIDTH take no part in the access.
   logic unused_saddr;
   assign unused_saddr = ^saddr;

   // Every output is updated on the edge that enters the state that owns it,
   // so the SRAM pins come straight from flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         a_q        <= '0;
         d_q        <= '0;
         w_q        <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '0;
         srdy       <= 1'b0;
         sdtr       <= '0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
      end else begin
         srdy <= 1'b0;
         case (state)
            IDLE: begin
               if (sval) begin
                  a_q       <= saddr[ADDR_WIDTH:2];
                  d_q       <= sdtw;
                  w_q       <= srw;
                  sram_addr <= {saddr[ADDR_WIDTH:2], 1'b0};
                  sram_ce_n <= 1'b0;
                  if (srw) begin
                     sram_dq_oe <= 1'b1;
                     sram_dq_o  <= sdtw[15:0];
                  end
                  state <= LO_ADDR;
               end
            end
            LO_ADDR, HI_ADDR: begin
               cnt <= 4'(WAIT_STATES - 1);
               if (w_q) sram_we_n <= 1'b0;
               else     sram_oe_n <= 1'b0;
               state <= (state == LO_ADDR) ? LO_STB : HI_STB;
            end
            LO_STB, HI_STB: begin
               if (cnt == 4'd0) begin
                  // Last strobe cycle: release the strobes and capture read data.
                  sram_we_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  if (!w_q) begin
                     if (state == LO_STB) lo_q <= sram_dq_i;
                     else                 hi_q <= sram_dq_i;
                  end
                  state <= (state == LO_STB) ? LO_REC : HI_REC;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            LO_REC: begin
               // Address and data were held through REC for hold after WE rise.
               sram_addr <= {a_q, 1'b1};
               if (w_q) sram_dq_o <= d_q[31:16];
               state <= HI_ADDR;
            end
            HI_REC: begin
               srdy       <= 1'b1;
               sram_ce_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               if (!w_q) sdtr <= {hi_q, lo_q};
               state <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
